// File: rtl/fattree_up_port_selector.sv
// Up-port selector for a fat-tree router. It locks one of K up ports for
// the length of a packet and keeps a downstream credit counter for each
// up port. The port is chosen by a destination digit, by round-robin, or
// by the most credits, depending on MODE.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no packet in flight; a valid head flit locks a port
//   LOCKED | flits of the current packet go to sel_port_o until the tail
module fattree_up_port_selector #(
    parameter int K     = 4,
    parameter int Kw    = 2,
    parameter int L     = 3,
    parameter int LKw   = 6,
    parameter int B     = 4,
    parameter int CRDw  = 3,
    parameter int MODE  = 2,
    parameter int DIGIT = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              req_head_i,
    input  logic              req_tail_i,
    input  logic [LKw-1:0]    req_dst_pos_i,
    output logic              req_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [K-1:0]      sel_port_o,
    input  logic [K-1:0]      credit_in_i,
    output logic [K*CRDw-1:0] credit_cnt_o,
    output logic              busy_o,
    output logic              err_ovf_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // An out-of-range digit index selects the most significant level instead.
    localparam int DIG_SEL = (DIGIT < L) ? DIGIT : L - 1;
    localparam logic [CRDw-1:0] B_C = CRDw'(B);

    logic [0:0]      state_q, state_d;
    logic [Kw-1:0]   port_q, port_d;
    logic [Kw-1:0]   rr_q, rr_d;
    logic [K-1:0]    sel_q, sel_d;
    logic            err_q, err_d;
    logic [CRDw-1:0] cnt_q [K];
    logic [CRDw-1:0] cnt_d [K];

    logic [Kw-1:0]   digit;
    logic [Kw-1:0]   best_port;
    logic [CRDw-1:0] best_cnt;
    logic [Kw-1:0]   scan_idx;
    logic [Kw-1:0]   pick;
    logic [K-1:0]    onehot_pick;
    logic            busy;
    logic            out_valid;
    logic            fire;
    logic            unused_dst;

    assign digit      = req_dst_pos_i[DIG_SEL*Kw +: Kw];
    // Only one digit of the destination matters here; the rest is routed
    // further up the tree.
    assign unused_dst = ^req_dst_pos_i;

    assign busy      = (state_q == ST_LOCKED);
    assign out_valid = busy & req_valid_i & (cnt_q[port_q] != '0);
    assign fire      = out_valid & out_ready_i;

    // Adaptive choice: largest registered counter, ties resolved by scanning
    // cyclically from rr_q and keeping only strictly larger counts.
    always_comb begin
        best_port = rr_q;
        best_cnt  = cnt_q[rr_q];
        scan_idx  = rr_q;
        for (int i = 1; i < K; i++) begin
            scan_idx = rr_q + Kw'(i);
            if (cnt_q[scan_idx] > best_cnt) begin
                best_cnt  = cnt_q[scan_idx];
                best_port = scan_idx;
            end
        end
    end

    // Port chosen if a head is locked this cycle, per the configured mode.
    always_comb begin
        pick = rr_q;
        if (MODE == 0) begin
            pick = digit;
        end else if (MODE == 1) begin
            pick = rr_q;
        end else begin
            pick = best_port;
        end
        onehot_pick       = '0;
        onehot_pick[pick] = 1'b1;
    end

    // Lock/unlock control and round-robin pointer advance.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_head_i) begin
                    state_d = ST_LOCKED;
                    port_d  = pick;
                    sel_d   = onehot_pick;
                    if (MODE != 0) begin
                        rr_d = pick + Kw'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (fire && req_tail_i) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // Credit counters: a returned credit and a forwarded flit on the same
    // port cancel; a return into a full counter is flagged, not counted.
    always_comb begin
        err_d = err_q;
        for (int p = 0; p < K; p++) begin
            cnt_d[p] = cnt_q[p];
            if (credit_in_i[p] && !(fire && sel_q[p])) begin
                if (cnt_q[p] == B_C) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[p] = cnt_q[p] + CRDw'(1);
                end
            end else if (!credit_in_i[p] && fire && sel_q[p]) begin
                cnt_d[p] = cnt_q[p] - CRDw'(1);
            end
        end
    end

    // State, lock and credit registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            port_q  <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            for (int p = 0; p < K; p++) begin
                cnt_q[p] <= B_C;
            end
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            for (int p = 0; p < K; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    for (genvar p = 0; p < K; p++) begin : g_cnt_out
        assign credit_cnt_o[p*CRDw +: CRDw] = cnt_q[p];
    end

    assign req_ready_o = fire;
    assign out_valid_o = out_valid;
    assign sel_port_o  = sel_q;
    assign busy_o      = busy;
    assign err_ovf_o   = err_q;

endmodule

// File: tb/tb_fattree_up_port_selector.sv
// Bench for fattree_up_port_selector: three instances (MODE 0 with DIGIT=1,
// MODE 1, MODE 2) with independent inputs, each tracked by a behavioural
// model that is compared on every falling clock edge, plus directed
// scenarios with literal expectations.
module tb_fattree_up_port_selector;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       rv   [3];
    logic       hd   [3];
    logic       tl   [3];
    logic       ordy [3];
    logic [5:0] dst  [3];
    logic [3:0] cr   [3];

    logic        rdy_o [3];
    logic        ov    [3];
    logic        bz    [3];
    logic        er    [3];
    logic [3:0]  sel   [3];
    logic [11:0] cc    [3];

    fattree_up_port_selector #(.MODE(0), .DIGIT(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[0]), .req_head_i(hd[0]),
        .req_tail_i(tl[0]), .req_dst_pos_i(dst[0]), .req_ready_o(rdy_o[0]),
        .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .sel_port_o(sel[0]),
        .credit_in_i(cr[0]), .credit_cnt_o(cc[0]), .busy_o(bz[0]), .err_ovf_o(er[0]));

    fattree_up_port_selector #(.MODE(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[1]), .req_head_i(hd[1]),
        .req_tail_i(tl[1]), .req_dst_pos_i(dst[1]), .req_ready_o(rdy_o[1]),
        .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .sel_port_o(sel[1]),
        .credit_in_i(cr[1]), .credit_cnt_o(cc[1]), .busy_o(bz[1]), .err_ovf_o(er[1]));

    fattree_up_port_selector #(.MODE(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[2]), .req_head_i(hd[2]),
        .req_tail_i(tl[2]), .req_dst_pos_i(dst[2]), .req_ready_o(rdy_o[2]),
        .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .sel_port_o(sel[2]),
        .credit_in_i(cr[2]), .credit_cnt_o(cc[2]), .busy_o(bz[2]), .err_ovf_o(er[2]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%0h expected=%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (instance index == mode) ----------------
    int m_lock [3];      // locked port, -1 when idle
    int m_cnt  [3][4];
    int m_rr   [3];
    bit m_err  [3];

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) begin
            m_lock[i] = -1;
            m_rr[i]   = 0;
            m_err[i]  = 1'b0;
            for (int p = 0; p < 4; p++) m_cnt[i][p] = 4;
        end
    endfunction

    function automatic int m_choose(input int i);
        int best;
        int bc;
        int q;
        if (i == 0) return (int'(dst[0]) >> 2) % 4;
        if (i == 1) return m_rr[1];
        best = -1;
        bc   = -1;
        for (int k = 0; k < 4; k++) begin
            q = (m_rr[2] + k) % 4;
            if (m_cnt[2][q] > bc) begin
                bc   = m_cnt[2][q];
                best = q;
            end
        end
        return best;
    endfunction

    function automatic void m_step(input int i);
        int  lp;
        int  p;
        bit  fire;
        bit  inc;
        bit  dec;
        lp   = m_lock[i];
        fire = (lp >= 0) && rv[i] && (m_cnt[i][lp] != 0) && ordy[i];
        p    = m_choose(i);
        for (int q = 0; q < 4; q++) begin
            inc = cr[i][q];
            dec = fire && (lp == q);
            if (inc && !dec) begin
                if (m_cnt[i][q] == 4) m_err[i] = 1'b1;
                else m_cnt[i][q]++;
            end else if (dec && !inc) begin
                m_cnt[i][q]--;
            end
        end
        if (lp < 0) begin
            if (rv[i] && hd[i]) begin
                m_lock[i] = p;
                if (i != 0) m_rr[i] = (p + 1) % 4;
            end
        end else if (fire && tl[i]) begin
            m_lock[i] = -1;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else for (int i = 0; i < 3; i++) m_step(i);
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        int          lp;
        logic        eov;
        logic [3:0]  esel;
        logic [11:0] ecc;
        if (!rst_n) m_reset();
        for (int i = 0; i < 3; i++) begin
            lp   = m_lock[i];
            eov  = (lp >= 0) && rv[i] && (m_cnt[i][lp] != 0);
            esel = '0;
            if (lp >= 0) esel[lp] = 1'b1;
            for (int p = 0; p < 4; p++) ecc[p*3 +: 3] = 3'(m_cnt[i][p]);
            chk("m_out_valid", i, 32'(ov[i]), 32'(eov));
            chk("m_req_ready", i, 32'(rdy_o[i]), 32'(eov && ordy[i]));
            chk("m_sel_port", i, 32'(sel[i]), 32'(esel));
            chk("m_credit_cnt", i, 32'(cc[i]), 32'(ecc));
            chk("m_busy", i, 32'(bz[i]), 32'(lp >= 0));
            chk("m_err_ovf", i, 32'(er[i]), 32'(m_err[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic credit(input int i, input int p);
        tick();
        cr[i] = 4'(1 << p);
        tick();
        cr[i] = 4'b0000;
    endtask

    task automatic send_pkt(input int i, input logic [5:0] d, input int n,
                            input logic [3:0] exp_sel);
        tick();
        rv[i] = 1'b1; hd[i] = 1'b1; tl[i] = (n == 1); dst[i] = d; ordy[i] = 1'b1;
        tick();
        @(negedge clk);
        chk("lock_sel", i, 32'(sel[i]), 32'(exp_sel));
        for (int f = 0; f < n; f++) begin
            if (f > 0) tick();
            hd[i] = (f == 0);
            tl[i] = (f == n - 1);
        end
        tick();
        rv[i] = 1'b0; hd[i] = 1'b0; tl[i] = 1'b0;
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", i, 32'(bz[i]), 32'd0);
            chk("rst_sel", i, 32'(sel[i]), 32'd0);
            chk("rst_cnt", i, 32'(cc[i]), 32'h924);
            chk("rst_err", i, 32'(er[i]), 32'd0);
            chk("rst_ready", i, 32'(rdy_o[i]), 32'd0);
        end
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 0; hd[i] = 0; tl[i] = 0; ordy[i] = 0; dst[i] = '0; cr[i] = '0;
        end
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        repeat (3) tick();
        @(negedge clk);
        chk_reset_state();
        tick();
        rst_n = 1'b1;

        // MODE 0, DIGIT=1: digit 1 of 00_10_01 is 2
        send_pkt(0, 6'b001001, 3, 4'b0100);
        @(negedge clk);
        chk("m0_cnt2_after3", 0, 32'(cc[0][8:6]), 32'd1);
        tick();
        rv[0] = 1; hd[0] = 1; tl[0] = 0; dst[0] = 6'b001001; ordy[0] = 1;
        tick();
        @(negedge clk);
        chk("m0_ov_cnt1", 0, 32'(ov[0]), 32'd1);
        tick();
        hd[0] = 0;
        @(negedge clk);
        chk("m0_ov_cnt0", 0, 32'(ov[0]), 32'd0);
        chk("m0_rdy_cnt0", 0, 32'(rdy_o[0]), 32'd0);
        chk("m0_cnt2_zero", 0, 32'(cc[0][8:6]), 32'd0);
        tick();
        @(negedge clk);
        chk("m0_ov_hold", 0, 32'(ov[0]), 32'd0);
        tick();
        cr[0] = 4'b0100;
        @(negedge clk);
        chk("m0_ov_credit_cycle", 0, 32'(ov[0]), 32'd0);
        tick();
        cr[0] = 4'b0000; tl[0] = 1;
        @(negedge clk);
        chk("m0_ov_after_credit", 0, 32'(ov[0]), 32'd1);
        tick();
        rv[0] = 0; tl[0] = 0;
        @(negedge clk);
        chk("m0_idle_after_tail", 0, 32'(bz[0]), 32'd0);
        repeat (4) credit(0, 2);

        // MODE 0 backpressure on port 1 (digit 1 of 00_01_00)
        tick();
        rv[0] = 1; hd[0] = 1; tl[0] = 0; dst[0] = 6'b000100; ordy[0] = 1;
        tick();
        @(negedge clk);
        chk("bp_sel", 0, 32'(sel[0]), 32'b0010);
        tick();
        hd[0] = 0; tl[0] = 1; ordy[0] = 0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready", 0, 32'(rdy_o[0]), 32'd0);
            chk("bp_busy", 0, 32'(bz[0]), 32'd1);
            chk("bp_sel_hold", 0, 32'(sel[0]), 32'b0010);
            chk("bp_cnt_hold", 0, 32'(cc[0][5:3]), 32'd3);
            tick();
        end
        ordy[0] = 1;
        @(negedge clk);
        chk("bp_release_ready", 0, 32'(rdy_o[0]), 32'd1);
        tick();
        rv[0] = 0; tl[0] = 0;
        @(negedge clk);
        chk("bp_idle", 0, 32'(bz[0]), 32'd0);
        chk("bp_cnt_after", 0, 32'(cc[0][5:3]), 32'd2);
        repeat (2) credit(0, 1);

        // MODE 1: single-flit packets back to back
        tick();
        rv[1] = 1; hd[1] = 1; tl[1] = 1; ordy[1] = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("rr_sel", 1, 32'(sel[1]), 32'(rr_exp[k]));
            chk("rr_ready", 1, 32'(rdy_o[1]), 32'd1);
            tick();
        end
        rv[1] = 0; hd[1] = 0; tl[1] = 0;

        // MODE 1: credit return on the firing port cancels the decrement
        tick();
        rv[1] = 1; hd[1] = 1; tl[1] = 0;
        tick();
        cr[1] = 4'b0010;
        @(negedge clk);
        chk("sim_sel", 1, 32'(sel[1]), 32'b0010);
        chk("sim_ready", 1, 32'(rdy_o[1]), 32'd1);
        tick();
        cr[1] = 4'b0000; hd[1] = 0; tl[1] = 1;
        @(negedge clk);
        chk("sim_cnt1_unchanged", 1, 32'(cc[1][5:3]), 32'd3);
        tick();
        rv[1] = 0; tl[1] = 0;
        @(negedge clk);
        chk("sim_cnt1_dec", 1, 32'(cc[1][5:3]), 32'd2);
        credit(1, 3);
        @(negedge clk);
        chk("ovf_not_yet", 1, 32'(er[1]), 32'd0);
        chk("ovf_cnt3_full", 1, 32'(cc[1][11:9]), 32'd4);
        credit(1, 3);
        @(negedge clk);
        chk("ovf_set", 1, 32'(er[1]), 32'd1);
        chk("ovf_cnt3_sat", 1, 32'(cc[1][11:9]), 32'd4);
        repeat (3) tick();
        @(negedge clk);
        chk("ovf_sticky", 1, 32'(er[1]), 32'd1);

        // MODE 2: build counters {1,4,4,2} with rr_ptr=2
        send_pkt(2, 6'd0, 3, 4'b0001);
        send_pkt(2, 6'd0, 1, 4'b0010);
        credit(2, 1);
        send_pkt(2, 6'd0, 2, 4'b0100);
        send_pkt(2, 6'd0, 2, 4'b1000);
        send_pkt(2, 6'd0, 1, 4'b0010);
        credit(2, 1);
        credit(2, 2);
        credit(2, 2);
        @(negedge clk);
        chk("ad_counts", 2, 32'(cc[2]), 32'({3'd2, 3'd4, 3'd4, 3'd1}));
        send_pkt(2, 6'd0, 1, 4'b0100);
        credit(2, 2);
        send_pkt(2, 6'd0, 1, 4'b0010);

        // Reset in the middle of a packet
        tick();
        rv[0] = 1; hd[0] = 1; tl[0] = 0; dst[0] = 6'd0; ordy[0] = 1;
        tick();
        tick();
        hd[0] = 0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_accept", 0, 32'(rdy_o[0]), 32'd0);
            chk("post_rst_idle", 0, 32'(bz[0]), 32'd0);
            tick();
        end
        rv[0] = 0;

        // Random traffic on all three instances
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            rst_n = ($urandom % 700 == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 3; i++) begin
                rv[i]   = ($urandom % 4) != 0;
                hd[i]   = ($urandom % 3) == 0;
                tl[i]   = ($urandom % 3) == 0;
                dst[i]  = 6'($urandom);
                ordy[i] = ($urandom % 4) != 0;
                for (int p = 0; p < 4; p++) cr[i][p] = ($urandom % 6) == 0;
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fattree_up_port_selector.md
Name: fattree_up_port_selector

Overview:
- Per-router up-link selection engine for the next-generation fat-tree NoC; sits between a leaf/intermediate router's route-compute stage and its K up ports.
- Locks one up port per packet (head to tail) and tracks per-up-port downstream credits.
- Replaces fixed up-port wiring with three run-time-independent modes: deterministic destination-digit, round-robin, and credit-adaptive.
- Generalised in K, buffer depth, address width and mode.

Parameters:
- K, 4, number of up ports (power of two, >=2)
- Kw, 2, log2(K)
- L, 3, tree levels
- LKw, 6, destination position width (L*Kw)
- B, 4, credits per up port at reset (downstream buffer depth)
- CRDw, 3, credit counter width (holds 0..B)
- MODE, 2, 0 = DETERMINISTIC, 1 = ROUND_ROBIN, 2 = ADAPTIVE
- DIGIT, 0, index of the destination digit used in MODE 0

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  flit present from route-compute stage
- req_head  in  1  current flit is a head
- req_tail  in  1  current flit is a tail (head and tail may both be 1)
- req_dst_pos  in  LKw  destination position address, sampled on head
- req_ready  out  1  flit accepted this cycle (flit_fire)
- out_valid  out  1  flit forwarded to the selected up port
- out_ready  in  1  up-port crossbar can take the flit
- sel_port  out  K  one-hot locked up port, zero when idle
- credit_in  in  K  per-port credit return, one per cycle max per port
- credit_cnt  out  K*CRDw  current credit counters, port p at bits [p*CRDw +: CRDw]
- busy  out  1  state == LOCKED
- err_ovf  out  1  sticky: credit returned while counter == B

Behaviour:
Reset (reset=0, async):
- state = IDLE, sel_port = 0, rr_ptr = 0.
- All counters = B, err_ovf = 0.
- req_ready, out_valid, busy = 0.
- Mid-packet reset drops the lock immediately.

IDLE:
- On req_valid & req_head at edge t, latch the choice into sel_port and go to LOCKED.
- sel_port is visible from t+1.
- Non-head flits in IDLE are never accepted (req_ready = 0).

Choice at lock:
- MODE 0: p = (req_dst_pos >> DIGIT*Kw) & (K-1).
- MODE 1: p = rr_ptr.
- MODE 2: p = port with maximum credit_cnt. Ties go to the first port at or after rr_ptr in cyclic order.
- MODES 1 and 2: rr_ptr <= (p+1) mod K on each lock.

LOCKED:
- out_valid = req_valid & (cnt[p] != 0), combinational.
- flit_fire = out_valid & out_ready.
- req_ready = flit_fire.
- On flit_fire & req_tail: state <= IDLE and sel_port <= 0 on the same edge.
- A single-flit packet therefore occupies 1 cycle after the lock cycle.
- Minimum head latency: 1 cycle; back-to-back packets incur 1 idle cycle between tail and next head.

Credits, per port p, each cycle:
- dec = flit_fire & sel_port[p]; inc = credit_in[p].
- inc & dec: counter unchanged.
- dec only: counter - 1. Cannot underflow, because out_valid requires cnt != 0.
- inc only: counter + 1, saturating at B. If counter already == B, hold B and set err_ovf (sticky until reset).
- Counters update in every state, including IDLE.

Choice and credit timing:
- ADAPTIVE compares the registered counters of the lock cycle.
- A credit arriving in the same cycle is not considered.

Test Plan:
- Reset: K=4, B=4, assert reset low mid-packet -> busy=0, sel_port=0, every credit_cnt=4, err_ovf=0 while low; no flits accepted until the next head.
- MODE 0, DIGIT=1: head with dst_pos=6'b00_10_01 -> sel_port=4'b0100 at t+1; 3-flit packet leaves port 2 cnt=1; out_valid drops with cnt=0 until credit_in[2] pulses.
- MODE 1: four single-flit packets back-to-back, no credit stalls -> sel_port sequence 0001, 0010, 0100, 1000, then wraps to 0001.
- MODE 2: counters {p0=1, p1=4, p2=4, p3=2}, rr_ptr=2 -> lock port 2; next packet with counts unchanged -> port 1 (rr_ptr=3, scan 3,0,1).
- Simultaneous events: flit_fire on port 1 and credit_in[1] in the same cycle -> cnt[1] unchanged. credit_in[3] with cnt[3]=4 -> cnt stays 4, err_ovf=1 and stays 1.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> req_ready=0, lock and counters held; no tail release until a tail fires.
